// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: size encodings, controller states and request legality check.
package lsu_mem_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, RESP} state_e;

  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b11 || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       off_i,
  input  logic [1:0]       size_i,
  input  logic             uns_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] load_o,
  output logic [WIDTH-1:0] store_o
);
  logic [4:0]       sh_amt;
  logic [WIDTH-1:0] sh, mask;

  assign sh_amt = {off_i, 3'b000};
  assign sh     = rdata_i >> sh_amt;
  assign mask   = size_i == SZ_BYTE ? WIDTH'(8'hFF) : size_i == SZ_HALF ? WIDTH'(16'hFFFF) : '1;
  assign load_o = size_i == SZ_BYTE ? {{(WIDTH-8){~uns_i & sh[7]}}, sh[7:0]} :
                  size_i == SZ_HALF ? {{(WIDTH-16){~uns_i & sh[15]}}, sh[15:0]} : sh;
  assign store_o = (rdata_i & ~(mask << sh_amt)) | ((wdata_i & mask) << sh_amt);
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: turns byte/half/word load-store requests into aligned word accesses
// on a single-port BRAM with one-cycle read latency (read-modify-write for sub-word stores).
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d, data_q, data_d, ld_data, st_data;
  logic [1:0]       size_q, size_d;
  logic             we_q, we_d, uns_q, uns_d, err_q, err_d, bad, word_st;

  lsu_lane_align #(.WIDTH(WIDTH)) u_align (
    .off_i  (addr_q[1:0]),
    .size_i (size_q),
    .uns_i  (uns_q),
    .rdata_i(mem_rdata),
    .wdata_i(data_q),
    .load_o (ld_data),
    .store_o(st_data)
  );

  assign bad     = bad_req(req_size, req_addr[1:0]);
  assign word_st = we_q && size_q == SZ_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  // data_q holds store data, then the merged word (stores) or the extended result (loads)
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        data_d  = req_wdata;
        size_d  = req_size;
        we_d    = req_we;
        uns_d   = req_unsigned;
        err_d   = bad;
        state_d = bad ? RESP : ACCESS;
      end
      ACCESS: state_d = word_st ? RESP : WAIT;
      WAIT: begin
        data_d  = we_q ? st_data : ld_data;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid && !we_q && !err_q ? data_q : '0;
  assign mem_we     = (state_q == ACCESS && word_st) || state_q == WRITE;
  assign mem_addr   = {2'b00, addr_q[WIDTH-1:2]};
  assign mem_wdata  = data_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: random and directed requests against a behavioural BRAM,
// checked every cycle against a byte-level reference model of the load/store rules.
module tb_lsu_mem_ctrl;
  logic        clk, rst_n, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, mem_we;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;
  logic [31:0] bram [256];
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          acc;
    int          rc;
    int          wc;
    bit          st;
    bit          err;
    logic [31:0] rd;
    logic [31:0] wa;
    logic [31:0] wd;
    bit          lit_en;
    logic [31:0] lit;
  } exp_t;
  exp_t q[$];

  lsu_mem_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) bram[pl_idx] <= pl_dat;
    else if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= bram[mem_addr[7:0]];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask

  // reference: memory as bytes, loads extended arithmetically
  task automatic model(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, inout exp_t e);
    int idx = int'((a >> 2) & 32'hFF);
    int off = int'(a % 4);
    int nb  = sz == 2'd0 ? 1 : 2;
    int lat;
    logic [31:0] w = ref_mem[idx];
    longint v;
    e.err = sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    e.st = we && !e.err;
    e.rd = 0;
    e.wa = a / 4;
    e.wd = 0;
    if (e.err) lat = 1;
    else if (we) begin
      if (sz == 2'd2) w = wd;
      else if (sz == 2'd0) w[8*off +: 8] = wd[7:0];
      else w[8*off +: 16] = wd[15:0];
      ref_mem[idx] = w;
      e.wd = w;
      lat = sz == 2'd2 ? 2 : 4;
    end else begin
      lat = 3;
      if (sz == 2'd2) e.rd = w;
      else begin
        v = longint'(w >> (8*off)) % (64'd1 << (8*nb));
        if (!uns && v >= (64'd1 << (8*nb-1))) v = v - (64'd1 << (8*nb));
        e.rd = v[31:0];
      end
    end
    e.rc = e.acc + lat - 1;
    e.wc = e.acc + lat - 2;
  endtask

  // called at a negedge; returns at the negedge following the accept edge
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold, input bit lit_en,
                       input logic [31:0] lit, input bit track);
    exp_t e;
    int n = 0;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout req_ready stuck low at cycle %0d", cyc);
      req_valid = 0;
      return;
    end
    e.acc = cyc + 1;
    e.lit_en = lit_en;
    e.lit = lit;
    if (track) begin
      model(we, sz, uns, a, wd, e);
      if (lit_en) chk("model_literal", e.st ? e.wd : e.rd, lit);
    end else begin
      e.rc = -9; e.wc = -9; e.st = 0; e.err = 0; e.rd = 0; e.wa = 0; e.wd = 0;
    end
    q.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 0;
  endtask

  always @(negedge clk) begin
    bit busy, ev, ew;
    busy = q.size() > 0 && q[0].acc <= cyc;
    ev   = q.size() > 0 && q[0].rc == cyc;
    ew   = q.size() > 0 && q[0].st && q[0].wc == cyc;
    chk("req_ready", 32'(req_ready), 32'(!busy));
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    chk("mem_we", 32'(mem_we), 32'(ew));
    if (ew) begin
      chk("mem_addr", mem_addr, q[0].wa);
      chk("mem_wdata", mem_wdata, q[0].wd);
      if (q[0].lit_en) chk("mem_wdata_literal", mem_wdata, q[0].lit);
    end
    if (ev) begin
      chk("resp_err", 32'(resp_err), 32'(q[0].err));
      chk("resp_rdata", resp_rdata, q[0].rd);
      if (q[0].lit_en && !q[0].st) chk("resp_rdata_literal", resp_rdata, q[0].lit);
      void'(q.pop_front());
    end
  end

  initial begin
    int n;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    pl_en = 0; pl_idx = 0; pl_dat = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pl_en = 1; pl_idx = 8'(i); pl_dat = $urandom;
      ref_mem[i] = pl_dat;
    end
    @(negedge clk);
    pl_en = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // word round trip
    issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1);
    issue(0, 2'd2, 0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 1);
    // byte/half load extension
    issue(1, 2'd2, 0, 32'h20, 32'h80FF7F01, 0, 1, 32'h80FF7F01, 1);
    issue(0, 2'd0, 0, 32'h21, 0, 0, 1, 32'h0000007F, 1);
    issue(0, 2'd0, 0, 32'h22, 0, 0, 1, 32'hFFFFFFFF, 1);
    issue(0, 2'd0, 1, 32'h23, 0, 0, 1, 32'h00000080, 1);
    issue(0, 2'd1, 0, 32'h22, 0, 0, 1, 32'hFFFF80FF, 1);
    // byte store read-modify-write
    issue(1, 2'd2, 0, 32'h30, 32'h11223344, 0, 1, 32'h11223344, 1);
    issue(1, 2'd0, 0, 32'h31, 32'h000000AA, 0, 1, 32'h1122AA44, 1);
    // misaligned and illegal
    issue(0, 2'd2, 0, 32'h02, 0, 0, 1, 0, 1);
    issue(1, 2'd1, 0, 32'h05, 32'h1234, 0, 1, 0, 1);
    issue(0, 2'd3, 0, 32'h00, 0, 0, 1, 0, 1);
    // top of address space
    issue(1, 2'd2, 0, 32'hFFFFFFFC, 32'h0BADCAFE, 0, 1, 32'h0BADCAFE, 1);
    issue(0, 2'd2, 0, 32'hFFFFFFFC, 0, 0, 1, 32'h0BADCAFE, 1);
    // reset during WAIT of a half store: aborted, memory untouched
    issue(1, 2'd2, 0, 32'h40, 32'h12345678, 0, 1, 32'h12345678, 1);
    issue(1, 2'd1, 0, 32'h40, 32'h0000BEEF, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(0, 2'd2, 0, 32'h40, 0, 0, 1, 32'h12345678, 1);
    // back-to-back with req_valid held
    issue(1, 2'd2, 0, 32'h50, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D, 1);
    issue(0, 2'd2, 0, 32'h50, 0, 1, 1, 32'hCAFEF00D, 1);
    issue(1, 2'd0, 0, 32'h52, 32'h0000005A, 1, 1, 32'hCA5AF00D, 1);
    issue(0, 2'd0, 1, 32'h52, 0, 0, 1, 32'h0000005A, 1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit hold = ($urandom % 3) == 0;
      logic [1:0] sz = ($urandom % 16) == 0 ? 2'd3 : 2'($urandom % 3);
      logic [31:0] a = ($urandom % 16) == 0 ? $urandom : $urandom % 1024;
      issue(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, hold, 0, 0, 1);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 0;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout %0d responses outstanding", q.size());
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) chk($sformatf("final_mem_%0d", i), bram[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that initiates every data-memory access from the processor's memory stage into the single-port data BRAM. The BRAM is word-wide, has one write-enable bit and no byte enables. The block therefore converts byte and halfword accesses into aligned word accesses: extraction and sign-extension for loads, read-modify-write for stores. It also absorbs the BRAM's one-cycle read latency behind a valid/ready request and a one-cycle response pulse.

## Interface
Parameters:
- WIDTH, 32, data and byte-address width; fixed at 32 for this core.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, pipeline presents a memory request.
- req_ready, out, 1, controller can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_size, in, 2, 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned, in, 1, zero-extend loads when 1; ignored for stores.
- req_addr, in, WIDTH, byte address.
- req_wdata, in, WIDTH, store data, right-justified.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, WIDTH, load result; 0 for stores and errors.
- resp_err, out, 1, misaligned or illegal-size request; no memory access was made.
- mem_addr, out, WIDTH, word address to BRAM, equal to latched req_addr >> 2.
- mem_wdata, out, WIDTH, word written to BRAM.
- mem_we, out, 1, BRAM write enable.
- mem_rdata, in, WIDTH, BRAM read data, valid one cycle after the address is presented with mem_we = 0.

## Operation
- States: IDLE, ACCESS, WAIT, WRITE, RESP.
- **IDLE.** req_ready = 1. On req_valid && req_ready, latch addr, size, we, unsigned and wdata.
  - Illegal or misaligned request: go to RESP with error. Illegal is size 11. Misaligned is a half with addr[0] = 1, or a word with addr[1:0] != 0.
  - Otherwise go to ACCESS.
- **ACCESS.** Drive mem_addr.
  - Word store: mem_we = 1, mem_wdata = latched wdata, go to RESP.
  - Load or sub-word store: mem_we = 0, go to WAIT.
- **WAIT.** mem_rdata is valid this cycle.
  - Load: select the lane by addr[1:0] (little-endian), sign- or zero-extend, register the result, go to RESP.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the addressed lane of mem_rdata, register the merged word, go to WRITE.
- **WRITE.** mem_we = 1, mem_wdata = merged word, go to RESP.
- **RESP.** resp_valid = 1, req_ready = 0, go to IDLE.
- mem_we is decoded from state only (ACCESS-word-store or WRITE). It is never asserted in IDLE, WAIT or RESP.
- One request in flight at a time; no back-to-back acceptance while busy.

## Timing
Cycle 0 is the accept edge. resp_valid is high in:
- cycle 1 for an error;
- cycle 2 for a word store;
- cycle 3 for a load;
- cycle 4 for a byte or half store.

Minimum request-to-request spacing is the latency + 1, because IDLE is re-entered after RESP.

Reset values (asynchronous):
- state = IDLE, so req_ready = 1.
- resp_valid = 0, resp_err = 0, resp_rdata = 0.
- mem_we = 0, mem_addr = 0, mem_wdata = 0.

Boundary conditions:
- **Reset mid-operation:** the request is aborted with no response. If reset hits before WRITE, no partial write reaches memory. mem_we drops asynchronously.
- **req_valid held through RESP:** the request is not accepted until IDLE, so accept no earlier than the cycle after the response.
- **Address 0xFFFF_FFFC word:** legal; mem_addr = 0x3FFF_FFFF; no wrap issue.
- **Upper addr bits:** passed through undecoded; BRAM depth truncation belongs to the memory wrapper.

## Structure
- Shared package holds:
  - size encodings: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - state enum.
- One combinational sub-module, lsu_lane_align, performs load extraction/extension and store merge from addr[1:0], size, unsigned, rdata and wdata. The FSM and registers stay in lsu_mem_ctrl.

## Test plan
- **Word round trip:** store word 0xDEADBEEF @0x10, then load word @0x10. Required: mem_we pulse in cycle 1 with mem_addr = 0x4; load resp_rdata = 0xDEADBEEF in cycle 3.
- **Byte load with extension:** memory word @0x20 = 0x80FF7F01.
  - lb @0x21 → 0x0000007F.
  - lb @0x22 → 0xFFFFFFFF.
  - lbu @0x23 → 0x00000080.
  - lh @0x22 → 0xFFFF80FF.
- **Byte store RMW:** word @0x30 = 0x11223344; sb 0xAA @0x31. Required: exactly one mem_we, in cycle 3, with mem_wdata = 0x1122AA44; resp_valid in cycle 4.
- **Misaligned and illegal:** lw @0x02, sh @0x05, size 11 @0x00. Each gives resp_valid with resp_err = 1 in cycle 1 and mem_we never asserted.
- **Reset mid-RMW:** drop rst_n during WAIT of sh 0xBEEF @0x40. Required: no mem_we, no resp_valid, req_ready = 1 immediately, memory @0x40 unchanged.
- **Back-to-back:** req_valid held high with four requests. Required: req_ready low from accept through RESP, and responses in request order.
